// File: rtl/usb_rx_packet_parser.sv
// USB receive packet parser: frames FIFO bytes into packets, checks PID, CRC5 and CRC16,
// streams DATA payload with the CRC bytes stripped and pulses one status per packet.
module usb_rx_packet_parser #(
  parameter int unsigned MAX_PAYLOAD = 64,
  parameter int unsigned CNT_W       = $clog2(MAX_PAYLOAD + 4)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       fifo_data,
  input  logic             fifo_empty,
  input  logic             rcving,
  input  logic             r_error,
  output logic             r_enable,
  output logic             pld_valid,
  output logic [7:0]       pld_data,
  output logic             pkt_valid,
  output logic             pkt_err,
  output logic [2:0]       err_code,
  output logic [3:0]       pkt_pid,
  output logic [6:0]       pkt_addr,
  output logic [3:0]       pkt_endp,
  output logic [CNT_W-1:0] pld_count
);

  typedef enum logic [2:0] {S_IDLE, S_TOKEN, S_DATA, S_HSK, S_DRAIN} state_t;

  localparam logic [2:0]       ERR_PID   = 3'd1;
  localparam logic [2:0]       ERR_CRC5  = 3'd2;
  localparam logic [2:0]       ERR_CRC16 = 3'd3;
  localparam logic [2:0]       ERR_LEN   = 3'd4;
  localparam logic [2:0]       ERR_RX    = 3'd5;
  localparam logic [4:0]       CRC5_RES  = 5'b01100;
  localparam logic [15:0]      CRC16_RES = 16'h800D;
  localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_PAYLOAD + 3);

  // Bits arrive LSB first, so the register is fed byte bit 0 first.
  function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] b);
    logic [4:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[4] ^ b[i]) r = {r[3:0], 1'b0} ^ 5'b00101;
      else             r = {r[3:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       crc5_q, crc5_d;
  logic [15:0]      crc16_q, crc16_d;
  logic [7:0]       h0_q, h0_d, h1_q, h1_d;
  logic [3:0]       pid_s_q, pid_s_d;
  logic [6:0]       addr_s_q, addr_s_d;
  logic [3:0]       endp_s_q, endp_s_d;
  logic             pld_valid_q, pld_valid_d;
  logic [7:0]       pld_data_q, pld_data_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic             pkt_err_q, pkt_err_d;
  logic [2:0]       err_code_q, err_code_d;
  logic [3:0]       pkt_pid_q, pkt_pid_d;
  logic [6:0]       pkt_addr_q, pkt_addr_d;
  logic [3:0]       pkt_endp_q, pkt_endp_d;
  logic [CNT_W-1:0] pld_count_q, pld_count_d;
  logic             eop, fail, fail_drain, done;
  logic [2:0]       fail_code;

  assign r_enable = !rst && !fifo_empty;
  assign eop      = !rcving && fifo_empty;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    crc5_d      = crc5_q;
    crc16_d     = crc16_q;
    h0_d        = h0_q;
    h1_d        = h1_q;
    pid_s_d     = pid_s_q;
    addr_s_d    = addr_s_q;
    endp_s_d    = endp_s_q;
    pld_valid_d = 1'b0;
    pld_data_d  = pld_data_q;
    pkt_valid_d = 1'b0;
    pkt_err_d   = 1'b0;
    err_code_d  = err_code_q;
    pkt_pid_d   = pkt_pid_q;
    pkt_addr_d  = pkt_addr_q;
    pkt_endp_d  = pkt_endp_q;
    pld_count_d = pld_count_q;
    fail        = 1'b0;
    fail_drain  = 1'b0;
    fail_code   = '0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: if (r_enable) begin
        if (fifo_data[7:4] != ~fifo_data[3:0]) begin
          fail = 1'b1; fail_code = ERR_PID; fail_drain = 1'b1;
        end else begin
          pid_s_d = fifo_data[3:0];
          cnt_d   = '0;
          crc5_d  = '1;
          crc16_d = '1;
          case (fifo_data[3:0])
            4'h1, 4'h9, 4'hD: state_d = S_TOKEN;
            4'h3, 4'hB:       state_d = S_DATA;
            4'h2, 4'hA, 4'hE: state_d = S_HSK;
            default: begin fail = 1'b1; fail_code = ERR_LEN; fail_drain = 1'b1; end
          endcase
        end
      end
      S_TOKEN: begin
        if (r_error) begin
          fail = 1'b1; fail_code = ERR_RX; fail_drain = 1'b1;
        end else if (r_enable) begin
          if (cnt_q == CNT_TWO) begin
            fail = 1'b1; fail_code = ERR_LEN; fail_drain = 1'b1;
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            crc5_d = crc5_byte(crc5_q, fifo_data);
            if (cnt_q == '0) begin
              addr_s_d = fifo_data[6:0];
              endp_s_d = {endp_s_q[3:1], fifo_data[7]};
            end else begin
              endp_s_d = {fifo_data[2:0], endp_s_q[0]};
            end
          end
        end else if (eop) begin
          if (cnt_q != CNT_TWO)       begin fail = 1'b1; fail_code = ERR_LEN;  end
          else if (crc5_q != CRC5_RES) begin fail = 1'b1; fail_code = ERR_CRC5; end
          else begin
            done       = 1'b1;
            pkt_addr_d = addr_s_q;
            pkt_endp_d = endp_s_q;
          end
        end
      end
      S_DATA: begin
        if (r_error) begin
          fail = 1'b1; fail_code = ERR_RX; fail_drain = 1'b1;
        end else if (r_enable) begin
          // Oversize is caught on the pop that would make the payload exceed the limit.
          if (cnt_q + CNT_W'(1) == CNT_LIMIT) begin
            fail = 1'b1; fail_code = ERR_LEN; fail_drain = 1'b1;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            crc16_d = crc16_byte(crc16_q, fifo_data);
            h0_d    = fifo_data;
            h1_d    = h0_q;
            if (cnt_q >= CNT_TWO) begin
              pld_valid_d = 1'b1;
              pld_data_d  = h1_q;
            end
          end
        end else if (eop) begin
          if (cnt_q < CNT_TWO)           begin fail = 1'b1; fail_code = ERR_LEN;   end
          else if (crc16_q != CRC16_RES) begin fail = 1'b1; fail_code = ERR_CRC16; end
          else begin
            done        = 1'b1;
            pld_count_d = cnt_q - CNT_TWO;
          end
        end
      end
      S_HSK: begin
        if (r_error)       begin fail = 1'b1; fail_code = ERR_RX;  fail_drain = 1'b1; end
        else if (r_enable) begin fail = 1'b1; fail_code = ERR_LEN; fail_drain = 1'b1; end
        else if (eop)      done = 1'b1;
      end
      S_DRAIN: if (eop) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
      pkt_err_d  = 1'b1;
      err_code_d = fail_code;
      state_d    = fail_drain ? S_DRAIN : S_IDLE;
    end
    if (done) begin
      pkt_valid_d = 1'b1;
      pkt_pid_d   = pid_s_q;
      state_d     = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      crc5_q      <= '1;
      crc16_q     <= '1;
      h0_q        <= '0;
      h1_q        <= '0;
      pid_s_q     <= '0;
      addr_s_q    <= '0;
      endp_s_q    <= '0;
      pld_valid_q <= 1'b0;
      pld_data_q  <= '0;
      pkt_valid_q <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= '0;
      pkt_pid_q   <= '0;
      pkt_addr_q  <= '0;
      pkt_endp_q  <= '0;
      pld_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      crc5_q      <= crc5_d;
      crc16_q     <= crc16_d;
      h0_q        <= h0_d;
      h1_q        <= h1_d;
      pid_s_q     <= pid_s_d;
      addr_s_q    <= addr_s_d;
      endp_s_q    <= endp_s_d;
      pld_valid_q <= pld_valid_d;
      pld_data_q  <= pld_data_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_err_q   <= pkt_err_d;
      err_code_q  <= err_code_d;
      pkt_pid_q   <= pkt_pid_d;
      pkt_addr_q  <= pkt_addr_d;
      pkt_endp_q  <= pkt_endp_d;
      pld_count_q <= pld_count_d;
    end
  end

  assign pld_valid = pld_valid_q;
  assign pld_data  = pld_data_q;
  assign pkt_valid = pkt_valid_q;
  assign pkt_err   = pkt_err_q;
  assign err_code  = err_code_q;
  assign pkt_pid   = pkt_pid_q;
  assign pkt_addr  = pkt_addr_q;
  assign pkt_endp  = pkt_endp_q;
  assign pld_count = pld_count_q;

endmodule
